axi_stream_strip_header: RTL and testbench

- Receive-side counterpart of the header-insert path.
- Takes an AXI-stream packet whose first beat carries a header of strip_len bytes in its most-significant byte lanes.
- Emits the header on a dedicated header port, then re-packs the remaining payload into full MSB-aligned beats on the output stream.
- Sits between the link receiver and the payload consumer.

---
 rtl/axi_stream_strip_header_pkg.sv | 42 ++++
 rtl/axi_stream_strip_header_if.sv | 39 +++
 rtl/axi_stream_strip_header_merge.sv | 37 +++
 rtl/axi_stream_strip_header.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_stream_strip_header.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_stream_strip_header_pkg.sv
// Shared types and helpers for the AXI-stream header-strip block.
// Holds the FSM state encoding, the byte-count width rule and
// the keep popcount and count-to-mask helpers.
package axi_strip_pkg;

  // Widest beat the helpers handle, in bytes (512-bit data).
  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // A count of 0..W needs one bit more than a byte index.
  function automatic int cnt_width(input int byte_cnt_wd);
    return byte_cnt_wd + 1;
  endfunction

  // Number of set keep bits. Callers zero-extend narrower keeps.
  function automatic int unsigned keep_popcount(input logic [MAX_BYTES-1:0] keep);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      n += 32'(keep[i]);
    end
    return n;
  endfunction

  // Keep mask of a w-bit field with its top cnt bits set.
  // The result sits in the low w bits; callers truncate to w.
  function automatic logic [MAX_BYTES-1:0] cnt_to_mask(input int unsigned cnt,
                                                       input int unsigned w);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i < w && i + cnt >= w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_stream_strip_header_if.sv
// Handshake and data bundle for the header-strip block.
// slave is the view of the strip block itself; master is the view
// of the surrounding link receiver / header and payload consumers.
interface axi_stream_strip_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  // input stream
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;
  logic [BYTE_CNT_WD:0]    strip_len;
  // header port
  logic                    hdr_valid;
  logic [DATA_WD-1:0]      hdr_data;
  logic [DATA_BYTE_WD-1:0] hdr_keep;
  logic                    hdr_ready;
  // payload stream
  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  modport slave (
    input  valid_in, data_in, keep_in, last_in, strip_len, hdr_ready, ready_out,
    output ready_in, hdr_valid, hdr_data, hdr_keep, valid_out, data_out, keep_out,
           last_out
  );

  modport master (
    output valid_in, data_in, keep_in, last_in, strip_len, hdr_ready, ready_out,
    input  ready_in, hdr_valid, hdr_data, hdr_keep, valid_out, data_out, keep_out,
           last_out
  );
endinterface

// File: rtl/axi_stream_strip_header_merge.sv
// Combinational byte packer: appends the valid input bytes behind the
// residue bytes and splits the result into one MSB-aligned output beat
// and the left-over residue. Both operands must have unused lanes at 0.
module strip_byte_merge #(
  parameter int DATA_WD = 32,
  parameter int CNT_WD  = 3
) (
  input  logic [DATA_WD-1:0] res_data_i,
  input  logic [CNT_WD-1:0]  res_cnt_i,
  input  logic [DATA_WD-1:0] in_data_i,
  input  logic [CNT_WD-1:0]  in_cnt_i,
  output logic [DATA_WD-1:0] beat_o,
  output logic [DATA_WD-1:0] res_data_o,
  output logic [CNT_WD-1:0]  res_cnt_o,
  output logic [CNT_WD:0]    total_o,
  output logic               full_o,
  output logic               ovf_o
);

  localparam logic [CNT_WD:0] W_CNT = (CNT_WD + 1)'(DATA_WD / 8);

  logic [2*DATA_WD-1:0] cat;

  // residue bytes followed by input bytes; a full beat leaves the tail
  // as residue, otherwise everything stays in the residue
  always_comb begin
    total_o    = {1'b0, res_cnt_i} + {1'b0, in_cnt_i};
    cat        = {res_data_i, {DATA_WD{1'b0}}}
               | ({in_data_i, {DATA_WD{1'b0}}} >> {res_cnt_i, 3'b000});
    full_o     = (total_o >= W_CNT);
    ovf_o      = (total_o > W_CNT);
    beat_o     = cat[2*DATA_WD-1 -: DATA_WD];
    res_data_o = full_o ? cat[DATA_WD-1:0] : cat[2*DATA_WD-1 -: DATA_WD];
    res_cnt_o  = full_o ? CNT_WD'(total_o - W_CNT) : CNT_WD'(total_o);
  end

endmodule

// File: rtl/axi_stream_strip_header.sv
// AXI-stream header strip: the first beat's top strip_len bytes go out on
// the header port, the rest of the packet is re-packed into full
// MSB-aligned beats with one beat of lag.
// Optional macro STRIP_HDR_ERR_CNT_EN adds a saturating 16-bit err_cnt
// output counting packets that carried no payload bytes.
//
// state  | meaning
// FIRST  | waiting for the first beat of a packet (header beat)
// STREAM | mid-packet, packing residue + input into full beats
// FLUSH  | tail overflowed the last full beat; residue still to emit
module axi_stream_strip_header
  import axi_strip_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic clk,
  input  logic rst_n,
  axi_stream_strip_header_if.slave bus
`ifdef STRIP_HDR_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int CNT_WD = cnt_width(BYTE_CNT_WD);

  state_t                  state_q;
  logic                    hdr_valid_q;
  logic [DATA_WD-1:0]      hdr_data_q;
  logic [DATA_BYTE_WD-1:0] hdr_keep_q;
  logic                    valid_out_q;
  logic [DATA_WD-1:0]      data_out_q;
  logic [DATA_BYTE_WD-1:0] keep_out_q;
  logic                    last_out_q;
  logic [DATA_WD-1:0]      res_data_q;
  logic [CNT_WD-1:0]       res_cnt_q;

  logic                    slot_free;
  logic                    hdr_free;
  logic                    rdy_in;
  logic                    acc;
  logic [CNT_WD-1:0]       c_in;
  logic [CNT_WD-1:0]       s_in;
  logic [DATA_WD-1:0]      in_masked;
  logic [DATA_BYTE_WD-1:0] hdr_keep_d;
  logic [DATA_WD-1:0]      hdr_data_d;
  logic [DATA_WD-1:0]      first_res_d;
  logic [CNT_WD-1:0]       first_rcnt_d;
  logic                    empty_pl;
  logic [DATA_BYTE_WD-1:0] first_keep;
  logic [DATA_BYTE_WD-1:0] tail_keep;
  logic [DATA_BYTE_WD-1:0] flush_keep;

  logic [DATA_WD-1:0]      mg_beat;
  logic [DATA_WD-1:0]      mg_res;
  logic [CNT_WD-1:0]       mg_res_cnt;
  logic [CNT_WD:0]         mg_total;
  logic                    mg_full;
  logic                    mg_ovf;

  function automatic logic [DATA_WD-1:0] lanes(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      m[8*i +: 8] = {8{k[i]}};
    end
    return m;
  endfunction

  // handshakes and first-beat split of header / residue
  always_comb begin
    slot_free = !valid_out_q || bus.ready_out;
    hdr_free  = !hdr_valid_q || bus.hdr_ready;
    case (state_q)
      FIRST:   rdy_in = slot_free && hdr_free;
      STREAM:  rdy_in = slot_free;
      default: rdy_in = 1'b0;
    endcase
    acc          = bus.valid_in && rdy_in;
    c_in         = CNT_WD'(keep_popcount(MAX_BYTES'(bus.keep_in)));
    s_in         = bus.strip_len;
    in_masked    = bus.data_in & lanes(bus.keep_in);
    hdr_keep_d   = DATA_BYTE_WD'(cnt_to_mask(32'(s_in), DATA_BYTE_WD));
    hdr_data_d   = in_masked & lanes(hdr_keep_d);
    first_res_d  = in_masked << {s_in, 3'b000};
    empty_pl     = (c_in <= s_in);
    first_rcnt_d = empty_pl ? '0 : c_in - s_in;
    first_keep   = DATA_BYTE_WD'(cnt_to_mask(32'(first_rcnt_d), DATA_BYTE_WD));
    tail_keep    = DATA_BYTE_WD'(cnt_to_mask(32'(mg_total), DATA_BYTE_WD));
    flush_keep   = DATA_BYTE_WD'(cnt_to_mask(32'(res_cnt_q), DATA_BYTE_WD));
  end

  strip_byte_merge #(
    .DATA_WD (DATA_WD),
    .CNT_WD  (CNT_WD)
  ) u_merge (
    .res_data_i (res_data_q),
    .res_cnt_i  (res_cnt_q),
    .in_data_i  (in_masked),
    .in_cnt_i   (c_in),
    .beat_o     (mg_beat),
    .res_data_o (mg_res),
    .res_cnt_o  (mg_res_cnt),
    .total_o    (mg_total),
    .full_o     (mg_full),
    .ovf_o      (mg_ovf)
  );

  // packet FSM with registered header, payload and residue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FIRST;
      hdr_valid_q <= 1'b0;
      hdr_data_q  <= '0;
      hdr_keep_q  <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      last_out_q  <= 1'b0;
      res_data_q  <= '0;
      res_cnt_q   <= '0;
    end else begin
      if (hdr_valid_q && bus.hdr_ready) hdr_valid_q <= 1'b0;
      if (valid_out_q && bus.ready_out) valid_out_q <= 1'b0;
      case (state_q)
        FIRST: begin
          if (acc) begin
            hdr_valid_q <= 1'b1;
            hdr_data_q  <= hdr_data_d;
            hdr_keep_q  <= hdr_keep_d;
            if (!bus.last_in) begin
              res_data_q <= first_res_d;
              res_cnt_q  <= first_rcnt_d;
              state_q    <= STREAM;
            end else begin
              res_data_q <= '0;
              res_cnt_q  <= '0;
              if (!empty_pl) begin
                valid_out_q <= 1'b1;
                data_out_q  <= first_res_d;
                keep_out_q  <= first_keep;
                last_out_q  <= 1'b1;
              end
            end
          end
        end
        STREAM: begin
          if (acc) begin
            if (bus.last_in) begin
              valid_out_q <= 1'b1;
              data_out_q  <= mg_beat;
              if (mg_ovf) begin
                keep_out_q <= '1;
                last_out_q <= 1'b0;
                res_data_q <= mg_res;
                res_cnt_q  <= mg_res_cnt;
                state_q    <= FLUSH;
              end else begin
                keep_out_q <= tail_keep;
                last_out_q <= 1'b1;
                res_data_q <= '0;
                res_cnt_q  <= '0;
                state_q    <= FIRST;
              end
            end else begin
              res_data_q <= mg_res;
              res_cnt_q  <= mg_res_cnt;
              if (mg_full) begin
                valid_out_q <= 1'b1;
                data_out_q  <= mg_beat;
                keep_out_q  <= '1;
                last_out_q  <= 1'b0;
              end
            end
          end
        end
        FLUSH: begin
          if (slot_free) begin
            valid_out_q <= 1'b1;
            data_out_q  <= res_data_q;
            keep_out_q  <= flush_keep;
            last_out_q  <= 1'b1;
            res_data_q  <= '0;
            res_cnt_q   <= '0;
            state_q     <= FIRST;
          end
        end
        default: state_q <= FIRST;
      endcase
    end
  end

`ifdef STRIP_HDR_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // saturating count of packets whose single beat held only header bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (state_q == FIRST && acc && bus.last_in && empty_pl
                 && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign bus.ready_in  = rdy_in;
  assign bus.hdr_valid = hdr_valid_q;
  assign bus.hdr_data  = hdr_data_q;
  assign bus.hdr_keep  = hdr_keep_q;
  assign bus.valid_out = valid_out_q;
  assign bus.data_out  = data_out_q;
  assign bus.keep_out  = keep_out_q;
  assign bus.last_out  = last_out_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header at DATA_WD=32.
module tb_axi_stream_strip_header;

  logic clk;
  logic rst_n;
`ifdef STRIP_HDR_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  axi_stream_strip_header_if #(.DATA_WD(32)) bus ();

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef STRIP_HDR_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_hdr[$];
  logic [63:0] exp_pl[$];
  logic [63:0] act_hdr[$];
  logic [63:0] act_pl[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pl(input logic [31:0] d, input logic [3:0] k, input logic l);
    return 64'({l, k, d});
  endfunction

  function automatic logic [63:0] hd(input logic [31:0] d, input logic [3:0] k);
    return 64'({k, d});
  endfunction

  // capture every completed handshake on both output ports
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid_out && bus.ready_out)
        act_pl.push_back(pl(bus.data_out, bus.keep_out, bus.last_out));
      if (bus.hdr_valid && bus.hdr_ready)
        act_hdr.push_back(hd(bus.hdr_data, bus.hdr_keep));
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic [2:0] s);
    int n;
    n = 0;
    bus.valid_in  = 1'b1;
    bus.data_in   = d;
    bus.keep_in   = k;
    bus.last_in   = l;
    bus.strip_len = s;
    @(negedge clk);
    while (!bus.ready_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_in) chk("accept_timeout", 64'(bus.ready_in), 64'd1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_run(input string tag);
    chk({tag, "_hdr_count"}, 64'(act_hdr.size()), 64'(exp_hdr.size()));
    for (int i = 0; i < exp_hdr.size() && i < act_hdr.size(); i++)
      chk({tag, "_hdr"}, act_hdr[i], exp_hdr[i]);
    chk({tag, "_pl_count"}, 64'(act_pl.size()), 64'(exp_pl.size()));
    for (int i = 0; i < exp_pl.size() && i < act_pl.size(); i++)
      chk({tag, "_pl"}, act_pl[i], exp_pl[i]);
    exp_hdr.delete();
    exp_pl.delete();
    act_hdr.delete();
    act_pl.delete();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.keep_in   = '0;
    bus.last_in   = 1'b0;
    bus.strip_len = '0;
    bus.hdr_ready = 1'b1;
    bus.ready_out = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hdr_valid", 64'(bus.hdr_valid), 64'd0);
    chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
    chk("rst_last_out", 64'(bus.last_out), 64'd0);
    chk("rst_data_out", 64'(bus.data_out), 64'd0);
`ifdef STRIP_HDR_ERR_CNT_EN
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    idle(1);

    // s=1, tail overflows into a flush beat; strip_len on later beats ignored
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0, 3'd1);
    send_beat(32'hEEFF0011, 4'b1111, 1'b0, 3'd3);
    send_beat(32'h2233DEAD, 4'b1100, 1'b1, 3'd3);
    idle(6);
    exp_hdr.push_back(hd(32'hAA000000, 4'b1000));
    exp_pl.push_back(pl(32'hBBCCDDEE, 4'b1111, 1'b0));
    exp_pl.push_back(pl(32'hFF001122, 4'b1111, 1'b0));
    exp_pl.push_back(pl(32'h33000000, 4'b1000, 1'b1));
    compare_run("s1");

    // s=0 pass-through with one-beat lag
    send_beat(32'h01020304, 4'b1111, 1'b0, 3'd0);
    chk("s0_hdr_valid", 64'(bus.hdr_valid), 64'd1);
    chk("s0_hdr_keep", 64'(bus.hdr_keep), 64'd0);
    chk("s0_no_early_pl", 64'(bus.valid_out), 64'd0);
    send_beat(32'h05060708, 4'b1111, 1'b1, 3'd0);
    chk("s0_pl1", pl(bus.data_out, bus.keep_out, bus.last_out),
        pl(32'h01020304, 4'b1111, 1'b0));
    idle(1);
    chk("s0_pl2", pl(bus.data_out, bus.keep_out, bus.last_out),
        pl(32'h05060708, 4'b1111, 1'b1));
    idle(4);
    exp_hdr.push_back(hd(32'h00000000, 4'b0000));
    exp_pl.push_back(pl(32'h01020304, 4'b1111, 1'b0));
    exp_pl.push_back(pl(32'h05060708, 4'b1111, 1'b1));
    compare_run("s0");

    // s=3 on a 3-byte single beat: header only
    send_beat(32'h11223344, 4'b1110, 1'b1, 3'd3);
    idle(4);
    exp_hdr.push_back(hd(32'h11223300, 4'b1110));
    compare_run("s3");
`ifdef STRIP_HDR_ERR_CNT_EN
    chk("s3_err_cnt", 64'(err_cnt), 64'd1);
`endif

    // s=2, payload stalled five cycles mid-packet
    send_beat(32'hA1A2A3A4, 4'b1111, 1'b0, 3'd2);
    send_beat(32'hB1B2B3B4, 4'b1111, 1'b0, 3'd2);
    bus.ready_out = 1'b0;
    bus.valid_in  = 1'b1;
    bus.data_in   = 32'hC1C2C3C4;
    bus.keep_in   = 4'b1111;
    bus.last_in   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready_in", 64'(bus.ready_in), 64'd0);
      chk("bp_hold", pl(bus.data_out, bus.keep_out, {1'b0}) | 64'(bus.valid_out) << 40,
          pl(32'hA3A4B1B2, 4'b1111, 1'b0) | 64'd1 << 40);
    end
    @(posedge clk);
    #1;
    bus.ready_out = 1'b1;
    send_beat(32'hC1C2C3C4, 4'b1111, 1'b1, 3'd2);
    idle(6);
    exp_hdr.push_back(hd(32'hA1A20000, 4'b1100));
    exp_pl.push_back(pl(32'hA3A4B1B2, 4'b1111, 1'b0));
    exp_pl.push_back(pl(32'hB3B4C1C2, 4'b1111, 1'b0));
    exp_pl.push_back(pl(32'hC3C40000, 4'b1100, 1'b1));
    compare_run("bp");

    // header not taken: next packet's first beat must wait
    bus.hdr_ready = 1'b0;
    send_beat(32'hDEADBEEF, 4'b1111, 1'b1, 3'd1);
    bus.valid_in  = 1'b1;
    bus.data_in   = 32'h12345678;
    bus.keep_in   = 4'b1111;
    bus.last_in   = 1'b1;
    bus.strip_len = 3'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hs_ready_in", 64'(bus.ready_in), 64'd0);
      chk("hs_hdr_hold", hd(bus.hdr_data, bus.hdr_keep), hd(32'hDE000000, 4'b1000));
    end
    @(posedge clk);
    #1;
    bus.hdr_ready = 1'b1;
    send_beat(32'h12345678, 4'b1111, 1'b1, 3'd2);
    idle(5);
    exp_hdr.push_back(hd(32'hDE000000, 4'b1000));
    exp_hdr.push_back(hd(32'h12340000, 4'b1100));
    exp_pl.push_back(pl(32'hADBEEF00, 4'b1110, 1'b1));
    exp_pl.push_back(pl(32'h56780000, 4'b1100, 1'b1));
    compare_run("hs");

    // reset mid-packet, then a clean packet
    send_beat(32'h0A0B0C0D, 4'b1111, 1'b0, 3'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_hdr_valid", 64'(bus.hdr_valid), 64'd0);
    chk("mrst_hdr_data", 64'(bus.hdr_data), 64'd0);
    chk("mrst_valid_out", 64'(bus.valid_out), 64'd0);
    chk("mrst_data_out", 64'(bus.data_out), 64'd0);
    chk("mrst_last_out", 64'(bus.last_out), 64'd0);
`ifdef STRIP_HDR_ERR_CNT_EN
    chk("mrst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_beat(32'h01020304, 4'b1111, 1'b0, 3'd2);
    send_beat(32'h05060708, 4'b1111, 1'b1, 3'd2);
    idle(6);
    exp_hdr.push_back(hd(32'h01020000, 4'b1100));
    exp_pl.push_back(pl(32'h03040506, 4'b1111, 1'b0));
    exp_pl.push_back(pl(32'h07080000, 4'b1100, 1'b1));
    compare_run("mrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
